// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types and screen constants for the draw scheduler
// Purpose: FSM state encoding plus screen and pixel-field widths used by
//          draw_sched and draw_clear_sweep.
// Ports:   none (package).
package draw_pkg;

  localparam int SCR_W    = 160;
  localparam int SCR_H    = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  // Encodings are pinned so state values stay stable for anything decoding r_state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    RELEASE = 3'd4,
    NEXT    = 3'd5,
    FINISH  = 3'd6
  } state_t;

endpackage

// File: rtl/draw_clear_sweep.sv
// rtl/draw_clear_sweep.sv - raster x/y counter for the full-screen clear pass
// Purpose: steps x 0..SCR_W-1 (inner) and y 0..SCR_H-1 (outer), one pixel per
//          enabled cycle, wrapping to (0,0) after the last pixel.
// Ports:   i_clk, i_rst (async, active-high); i_en advances the raster;
//          o_x/o_y current pixel; o_last high while on the final pixel.
module draw_clear_sweep
  import draw_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end = (r_x == X_W'(SCR_W - 1));
  assign w_y_end = (r_y == Y_W'(SCR_H - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end & w_y_end;

endmodule

// File: rtl/draw_sched.sv
// rtl/draw_sched.sv - frame-level start/done scheduler and VGA write-port mux
// Purpose: on each accepted frame tick, optionally clears the screen, then
//          serves every drawing client in order with a start/done handshake,
//          forwarding the served client's pixel stream (1-cycle registered)
//          to the VGA adapter with that client's colour. A watchdog bounds
//          each client's WAIT phase and records a sticky per-client fault.
// Build:   define DRAW_SCHED_CLEAR_EN to build the CLEAR pass and its sweep.
// Ports:   i_clk, i_reset (async, active-high), i_frame_tick (frame request);
//          o_cli_start / i_cli_done handshake, i_cli_drawEn/i_cli_x/i_cli_y
//          packed per-client pixel streams; o_vga_x/o_vga_y/o_vga_colour/
//          o_vga_plot adapter port; o_busy, o_frame_done, o_overrun (sticky),
//          o_fault (sticky per client).
module draw_sched
  import draw_pkg::*;
#(
  parameter int                    N_CLI        = 4,
  parameter logic [3*N_CLI-1:0]    CLI_COLOURS  = {N_CLI{3'b111}},
  parameter logic [COLOUR_W-1:0]   CLEAR_COLOUR = 3'b000,
  parameter logic [15:0]           WAIT_MAX     = 16'd40000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_frame_tick,
  output logic [N_CLI-1:0]         o_cli_start,
  input  logic [N_CLI-1:0]         i_cli_done,
  input  logic [N_CLI-1:0]         i_cli_drawEn,
  input  logic [X_W*N_CLI-1:0]     i_cli_x,
  input  logic [Y_W*N_CLI-1:0]     i_cli_y,
  output logic [X_W-1:0]           o_vga_x,
  output logic [Y_W-1:0]           o_vga_y,
  output logic [COLOUR_W-1:0]      o_vga_colour,
  output logic                     o_vga_plot,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_overrun,
  output logic [N_CLI-1:0]         o_fault
);

  localparam int IDX_W = (N_CLI > 1) ? $clog2(N_CLI) : 1;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [15:0]           r_wait_cnt;
  logic [N_CLI-1:0]      r_cli_start;
  logic [X_W-1:0]        r_vga_x;
  logic [Y_W-1:0]        r_vga_y;
  logic [COLOUR_W-1:0]   r_vga_colour;
  logic                  r_vga_plot;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_overrun;
  logic [N_CLI-1:0]      r_fault;

  // Only the served client's signals are ever looked at.
  logic                  w_sel_done;
  logic                  w_sel_draw_en;
  logic [X_W-1:0]        w_sel_x;
  logic [Y_W-1:0]        w_sel_y;
  logic [COLOUR_W-1:0]   w_sel_colour;
  logic [N_CLI-1:0]      w_idx_onehot;
  logic                  w_idx_last;
  logic                  w_wait_expired;

  assign w_sel_done     = i_cli_done[r_idx];
  assign w_sel_draw_en  = i_cli_drawEn[r_idx];
  assign w_sel_x        = i_cli_x[r_idx*X_W +: X_W];
  assign w_sel_y        = i_cli_y[r_idx*Y_W +: Y_W];
  assign w_sel_colour   = CLI_COLOURS[r_idx*COLOUR_W +: COLOUR_W];
  assign w_idx_onehot   = N_CLI'(1) << r_idx;
  assign w_idx_last     = (r_idx == IDX_W'(N_CLI - 1));
  // Counter starts at 0 on the first WAIT cycle, so WAIT_MAX-1 marks the
  // WAIT_MAX-th cycle with start held.
  assign w_wait_expired = (r_wait_cnt == WAIT_MAX - 16'd1);

`ifdef DRAW_SCHED_CLEAR_EN
  localparam state_t FIRST_STATE = CLEAR;
  logic                  w_clr_en;
  logic [X_W-1:0]        w_clr_x;
  logic [Y_W-1:0]        w_clr_y;
  logic                  w_clr_last;

  assign w_clr_en = (r_state == CLEAR);

  draw_clear_sweep u_clear_sweep (
    .i_clk  (i_clk),
    .i_rst  (i_reset),
    .i_en   (w_clr_en),
    .o_x    (w_clr_x),
    .o_y    (w_clr_y),
    .o_last (w_clr_last)
  );
`else
  localparam state_t FIRST_STATE = START;
  logic [COLOUR_W-1:0]   w_unused_clear_colour;
  assign w_unused_clear_colour = CLEAR_COLOUR;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_wait_cnt   <= '0;
      r_cli_start  <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_fault      <= '0;
    end else begin
      r_vga_plot   <= 1'b0;
      r_frame_done <= 1'b0;
      // Any tick outside IDLE (FINISH included) is dropped and flagged.
      if (i_frame_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (i_frame_tick) begin
            r_state <= FIRST_STATE;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
        end
`ifdef DRAW_SCHED_CLEAR_EN
        CLEAR: begin
          r_vga_plot   <= 1'b1;
          r_vga_x      <= w_clr_x;
          r_vga_y      <= w_clr_y;
          r_vga_colour <= CLEAR_COLOUR;
          if (w_clr_last) begin
            r_state <= START;
            r_idx   <= '0;
          end
        end
`endif
        START: begin
          r_cli_start <= w_idx_onehot;
          r_wait_cnt  <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          r_vga_plot   <= w_sel_draw_en;
          r_vga_x      <= w_sel_x;
          r_vga_y      <= w_sel_y;
          r_vga_colour <= w_sel_colour;
          // done is checked first so a same-cycle timeout never faults.
          if (w_sel_done) begin
            r_cli_start <= '0;
            r_state     <= RELEASE;
          end else if (w_wait_expired) begin
            r_cli_start    <= '0;
            r_fault[r_idx] <= 1'b1;
            r_state        <= NEXT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        RELEASE: begin
          r_vga_plot   <= w_sel_draw_en;
          r_vga_x      <= w_sel_x;
          r_vga_y      <= w_sel_y;
          r_vga_colour <= w_sel_colour;
          if (!w_sel_done) begin
            r_state <= NEXT;
          end
        end
        NEXT: begin
          if (w_idx_last) begin
            r_state      <= FINISH;
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= START;
          end
        end
        FINISH: begin
          r_idx   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cli_start  = r_cli_start;
  assign o_vga_x      = r_vga_x;
  assign o_vga_y      = r_vga_y;
  assign o_vga_colour = r_vga_colour;
  assign o_vga_plot   = r_vga_plot;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;
  assign o_fault      = r_fault;

endmodule
